// File: rtl/midi_pkg.sv
// Shared MIDI definitions: status nibbles, message field positions and the decoded
// message kind used by the voice allocator and future controller handlers.
package midi_pkg;

    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_NOTE_OFF = 4'h8;

    localparam int unsigned MSG_STATUS_MSB = 23;
    localparam int unsigned MSG_STATUS_LSB = 16;
    localparam int unsigned MSG_DATA1_MSB  = 15;
    localparam int unsigned MSG_DATA1_LSB  = 8;
    localparam int unsigned MSG_DATA2_MSB  = 7;
    localparam int unsigned MSG_DATA2_LSB  = 0;

    typedef enum logic [1:0] {
        IGNORE,
        NOTE_ON,
        NOTE_OFF
    } msg_kind_e;

endpackage

// File: rtl/midi_msg_decode.sv
// Combinational decode of one 3-byte MIDI channel message into note-on / note-off / ignore,
// with the data bytes reduced to their 7-bit payload.
module midi_msg_decode
    import midi_pkg::*;
(
    input  logic [23:0] msg_i,
    input  logic [3:0]  channel_i,
    output msg_kind_e   kind_o,
    output logic [6:0]  note_o,
    output logic [6:0]  vel_o
);

    logic [7:0] status;
    logic [7:0] data1;
    logic [7:0] data2;
    logic       chan_ok;
    logic       data_ok;

    assign status  = msg_i[MSG_STATUS_MSB:MSG_STATUS_LSB];
    assign data1   = msg_i[MSG_DATA1_MSB:MSG_DATA1_LSB];
    assign data2   = msg_i[MSG_DATA2_MSB:MSG_DATA2_LSB];
    assign chan_ok = (status[3:0] == channel_i);
    // A data byte with bit 7 set is a stray status byte, so the message is malformed.
    assign data_ok = ~data1[7] & ~data2[7];

    assign note_o = data1[6:0];
    assign vel_o  = data2[6:0];

    always_comb begin
        kind_o = IGNORE;
        if (chan_ok && data_ok) begin
            if (status[7:4] == ST_NOTE_ON && data2[6:0] != 7'd0) begin
                kind_o = NOTE_ON;
            end else if (status[7:4] == ST_NOTE_OFF || status[7:4] == ST_NOTE_ON) begin
                kind_o = NOTE_OFF;
            end
        end
    end

endmodule

// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator: retrigger held note, else lowest free voice, else steal the
// least-recently-allocated voice. One message buffered while the scan FSM is busy.
module midi_voice_alloc
    import midi_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned CHANNEL    = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [23:0]             midi_msg_i,
    input  logic                    midi_msg_rdy_i,
    output logic [7*NUM_VOICES-1:0] voice_note_o,
    output logic [7*NUM_VOICES-1:0] voice_vel_o,
    output logic [NUM_VOICES-1:0]   voice_gate_o,
    output logic [NUM_VOICES-1:0]   voice_trig_o,
    output logic                    busy_o,
    output logic                    drop_o
);

    localparam int unsigned AGE_W = $clog2(NUM_VOICES);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StCommit
    } state_e;

    state_e          state_q, state_d;
    logic [23:0]     buf_q, buf_d;
    logic            buf_full_q, buf_full_d;
    msg_kind_e       kind_q, kind_d;
    logic [6:0]      wnote_q, wnote_d;
    logic [6:0]      wvel_q, wvel_d;
    logic [AGE_W-1:0] idx_q, idx_d;
    logic            hit_found_q, hit_found_d;
    logic [AGE_W-1:0] hit_idx_q, hit_idx_d;
    logic            free_found_q, free_found_d;
    logic [AGE_W-1:0] free_idx_q, free_idx_d;
    logic [AGE_W-1:0] oldest_idx_q, oldest_idx_d;

    logic [6:0]      vnote_q [NUM_VOICES];
    logic [6:0]      vnote_d [NUM_VOICES];
    logic [6:0]      vvel_q  [NUM_VOICES];
    logic [6:0]      vvel_d  [NUM_VOICES];
    logic [AGE_W-1:0] age_q  [NUM_VOICES];
    logic [AGE_W-1:0] age_d  [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [NUM_VOICES-1:0] trig_q, trig_d;
    logic            drop_q, drop_d;

    msg_kind_e       dec_kind;
    logic [6:0]      dec_note;
    logic [6:0]      dec_vel;
    logic            accept;
    logic            pop;
    logic [AGE_W-1:0] tgt;

    midi_msg_decode u_decode (
        .msg_i     (buf_q),
        .channel_i (4'(CHANNEL)),
        .kind_o    (dec_kind),
        .note_o    (dec_note),
        .vel_o     (dec_vel)
    );

    // IDLE always pops a full buffer (even for ignored messages), freeing room for a new one.
    assign pop    = buf_full_q & (state_q == StIdle);
    assign accept = midi_msg_rdy_i & (~buf_full_q | (state_q == StIdle));

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        buf_full_d   = buf_full_q & ~pop;
        kind_d       = kind_q;
        wnote_d      = wnote_q;
        wvel_d       = wvel_q;
        idx_d        = idx_q;
        hit_found_d  = hit_found_q;
        hit_idx_d    = hit_idx_q;
        free_found_d = free_found_q;
        free_idx_d   = free_idx_q;
        oldest_idx_d = oldest_idx_q;
        vnote_d      = vnote_q;
        vvel_d       = vvel_q;
        age_d        = age_q;
        gate_d       = gate_q;
        trig_d       = '0;
        drop_d       = midi_msg_rdy_i & ~accept;
        tgt          = '0;

        if (accept) begin
            buf_d      = midi_msg_i;
            buf_full_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (buf_full_q && dec_kind != IGNORE) begin
                    kind_d       = dec_kind;
                    wnote_d      = dec_note;
                    wvel_d       = dec_vel;
                    idx_d        = '0;
                    hit_found_d  = 1'b0;
                    free_found_d = 1'b0;
                    state_d      = StScan;
                end
            end
            StScan: begin
                if (!hit_found_q && gate_q[idx_q] && vnote_q[idx_q] == wnote_q) begin
                    hit_found_d = 1'b1;
                    hit_idx_d   = idx_q;
                end
                if (!free_found_q && !gate_q[idx_q]) begin
                    free_found_d = 1'b1;
                    free_idx_d   = idx_q;
                end
                if (age_q[idx_q] == AGE_MAX) begin
                    oldest_idx_d = idx_q;
                end
                if (idx_q == AGE_MAX) begin
                    state_d = StCommit;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StCommit: begin
                state_d = StIdle;
                if (kind_q == NOTE_ON) begin
                    tgt = hit_found_q ? hit_idx_q : (free_found_q ? free_idx_q : oldest_idx_q);
                    vnote_d[tgt] = wnote_q;
                    vvel_d[tgt]  = wvel_q;
                    gate_d[tgt]  = 1'b1;
                    trig_d[tgt]  = 1'b1;
                    // Younger voices age by one so the ages stay a permutation.
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (age_q[i] < age_q[tgt]) begin
                            age_d[i] = age_q[i] + 1'b1;
                        end
                    end
                    age_d[tgt] = '0;
                end else begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        if (gate_q[i] && vnote_q[i] == wnote_q) begin
                            gate_d[i] = 1'b0;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            kind_q       <= IGNORE;
            wnote_q      <= '0;
            wvel_q       <= '0;
            idx_q        <= '0;
            hit_found_q  <= 1'b0;
            hit_idx_q    <= '0;
            free_found_q <= 1'b0;
            free_idx_q   <= '0;
            oldest_idx_q <= '0;
            gate_q       <= '0;
            trig_q       <= '0;
            drop_q       <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                vnote_q[i] <= '0;
                vvel_q[i]  <= '0;
                age_q[i]   <= AGE_W'(i);
            end
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            buf_full_q   <= buf_full_d;
            kind_q       <= kind_d;
            wnote_q      <= wnote_d;
            wvel_q       <= wvel_d;
            idx_q        <= idx_d;
            hit_found_q  <= hit_found_d;
            hit_idx_q    <= hit_idx_d;
            free_found_q <= free_found_d;
            free_idx_q   <= free_idx_d;
            oldest_idx_q <= oldest_idx_d;
            gate_q       <= gate_d;
            trig_q       <= trig_d;
            drop_q       <= drop_d;
            vnote_q      <= vnote_d;
            vvel_q       <= vvel_d;
            age_q        <= age_d;
        end
    end

    always_comb begin
        voice_note_o = '0;
        voice_vel_o  = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note_o[7*i +: 7] = vnote_q[i];
            voice_vel_o[7*i +: 7]  = vvel_q[i];
        end
    end

    assign voice_gate_o = gate_q;
    assign voice_trig_o = trig_q;
    assign drop_o       = drop_q;
    // Busy covers the decode cycle of a message that will be acted on, through COMMIT.
    assign busy_o       = (state_q != StIdle) | (buf_full_q & (dec_kind != IGNORE));

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Scoreboard bench for midi_voice_alloc: a reference model predicts each voice-state update
// and its commit cycle; a monitor pops and compares whenever the outputs change.
module tb_midi_voice_alloc;

    localparam int NV = 4;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic [23:0]     midi_msg_i = '0;
    logic            midi_msg_rdy_i = 1'b0;
    logic [7*NV-1:0] voice_note_o;
    logic [7*NV-1:0] voice_vel_o;
    logic [NV-1:0]   voice_gate_o;
    logic [NV-1:0]   voice_trig_o;
    logic            busy_o;
    logic            drop_o;

    midi_voice_alloc #(
        .NUM_VOICES (NV),
        .CHANNEL    (0)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .midi_msg_i     (midi_msg_i),
        .midi_msg_rdy_i (midi_msg_rdy_i),
        .voice_note_o   (voice_note_o),
        .voice_vel_o    (voice_vel_o),
        .voice_gate_o   (voice_gate_o),
        .voice_trig_o   (voice_trig_o),
        .busy_o         (busy_o),
        .drop_o         (drop_o)
    );

    always #10 clk_i = ~clk_i;

    typedef struct {
        logic [7*NV-1:0] note;
        logic [7*NV-1:0] vel;
        logic [NV-1:0]   gate;
        logic [NV-1:0]   trig;
        int              cyc;
    } exp_t;

    exp_t exp_q[$];
    int   drop_exp_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   free_at = 0;
    int   p_last = -1;
    bit   busy_seen = 1'b0;

    logic [6:0] m_note [NV];
    logic [6:0] m_vel  [NV];
    bit         m_gate [NV];
    int         m_age  [NV];

    logic [7*NV-1:0] prev_note = '0;
    logic [7*NV-1:0] prev_vel = '0;
    logic [NV-1:0]   prev_gate = '0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_note[i] = '0;
            m_vel[i]  = '0;
            m_gate[i] = 1'b0;
            m_age[i]  = i;
        end
        free_at = 0;
        p_last  = -1;
    endtask

    // 0 = ignore, 1 = note on, 2 = note off (channel 0 only)
    function automatic int classify(input logic [23:0] m);
        logic [7:0] st;
        logic [7:0] d1;
        logic [7:0] d2;
        st = m[23:16];
        d1 = m[15:8];
        d2 = m[7:0];
        if (st[3:0] != 4'h0 || d1[7] || d2[7]) return 0;
        if (st[7:4] == 4'h9 && d2 != 8'h00) return 1;
        if (st[7:4] == 4'h8 || st[7:4] == 4'h9) return 2;
        return 0;
    endfunction

    task automatic push_snapshot(input logic [NV-1:0] trig, input int c);
        exp_t e;
        e.note = '0;
        e.vel  = '0;
        e.gate = '0;
        for (int i = 0; i < NV; i++) begin
            e.note[7*i +: 7] = m_note[i];
            e.vel[7*i +: 7]  = m_vel[i];
            e.gate[i]        = m_gate[i];
        end
        e.trig = trig;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic model_msg(input logic [23:0] m, input int c);
        int         k;
        int         tgt;
        int         old;
        bit         changed;
        logic [6:0] n;
        logic [NV-1:0] tr;
        k = classify(m);
        n = m[14:8];
        if (k == 1) begin
            tgt = -1;
            for (int i = 0; i < NV; i++) if (tgt < 0 && m_gate[i] && m_note[i] == n) tgt = i;
            for (int i = 0; i < NV; i++) if (tgt < 0 && !m_gate[i]) tgt = i;
            for (int i = 0; i < NV; i++) if (tgt < 0 && m_age[i] == NV - 1) tgt = i;
            old = m_age[tgt];
            for (int i = 0; i < NV; i++) if (m_age[i] < old) m_age[i]++;
            m_age[tgt]  = 0;
            m_note[tgt] = n;
            m_vel[tgt]  = m[6:0];
            m_gate[tgt] = 1'b1;
            tr = '0;
            tr[tgt] = 1'b1;
            push_snapshot(tr, c);
        end else if (k == 2) begin
            changed = 1'b0;
            for (int i = 0; i < NV; i++) begin
                if (m_gate[i] && m_note[i] == n) begin
                    m_gate[i] = 1'b0;
                    changed   = 1'b1;
                end
            end
            if (changed) push_snapshot('0, c);
        end
    endtask

    // Called right after a negedge; the pulse is sampled at edge cyc+1.
    task automatic send(input logic [23:0] m);
        int e;
        int p;
        e = cyc + 1;
        if (p_last > e) begin
            drop_exp_q.push_back(e);
        end else begin
            p      = (e + 1 > free_at) ? e + 1 : free_at;
            p_last = p;
            if (classify(m) == 0) begin
                free_at = p + 1;
            end else begin
                model_msg(m, p + NV + 1);
                free_at = p + NV + 2;
            end
        end
        midi_msg_i     = m;
        midi_msg_rdy_i = 1'b1;
        @(negedge clk_i);
        midi_msg_rdy_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic do_reset(input string tag);
        rst_ni         = 1'b0;
        midi_msg_rdy_i = 1'b0;
        exp_q.delete();
        drop_exp_q.delete();
        model_reset();
        #1;
        check({tag, "_note"}, 64'(voice_note_o), 64'h0);
        check({tag, "_vel"},  64'(voice_vel_o),  64'h0);
        check({tag, "_gate"}, 64'(voice_gate_o), 64'h0);
        check({tag, "_trig"}, 64'(voice_trig_o), 64'h0);
        check({tag, "_busy"}, 64'(busy_o),       64'h0);
        check({tag, "_drop"}, 64'(drop_o),       64'h0);
        idle(2);
        rst_ni = 1'b1;
    endtask

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_note = '0;
            prev_vel  = '0;
            prev_gate = '0;
        end else begin
            if (busy_o) busy_seen = 1'b1;
            if (drop_o) begin
                if (drop_exp_q.size() == 0) check("drop_unexpected", 64'h1, 64'h0);
                else check("drop_cycle", 64'(cyc), 64'(drop_exp_q.pop_front()));
            end
            if (voice_trig_o != '0 || voice_note_o != prev_note || voice_vel_o != prev_vel
                || voice_gate_o != prev_gate) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_update", 64'h1, 64'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("commit_cycle", 64'(cyc), 64'(e.cyc));
                    check("note", 64'(voice_note_o), 64'(e.note));
                    check("vel",  64'(voice_vel_o),  64'(e.vel));
                    check("gate", 64'(voice_gate_o), 64'(e.gate));
                    check("trig", 64'(voice_trig_o), 64'(e.trig));
                end
                prev_note = voice_note_o;
                prev_vel  = voice_vel_o;
                prev_gate = voice_gate_o;
            end
        end
    end

    initial begin
        model_reset();
        @(negedge clk_i);
        do_reset("rst0");

        // Single note-on lands on voice 0 six cycles after the ready pulse.
        send(24'h903C64);
        idle(10);

        // Fill all voices, then steal the oldest (voice 0).
        do_reset("rst1");
        send(24'h903C40);
        idle(8);
        send(24'h903E40);
        idle(8);
        send(24'h904040);
        idle(8);
        send(24'h904140);
        idle(8);
        send(24'h904340);
        idle(10);

        // Retrigger a held note, release it, then a no-op note-off.
        do_reset("rst2");
        send(24'h903C64);
        idle(8);
        send(24'h903C20);
        idle(8);
        send(24'h903C00);
        idle(8);
        send(24'h803C00);
        idle(8);

        // Messages that must be ignored without ever raising busy.
        busy_seen = 1'b0;
        send(24'h913C64);
        idle(3);
        send(24'hB00740);
        idle(3);
        send(24'h903CC0);
        idle(3);
        send(24'hE01020);
        idle(8);
        check("ignored_busy", 64'(busy_seen), 64'h0);

        // Three back-to-back pulses: two processed in order, third dropped.
        send(24'h903E10);
        send(24'h904011);
        send(24'h904112);
        idle(20);

        // Reset in the middle of a scan loses the message entirely.
        send(24'h903C64);
        idle(2);
        do_reset("rst_mid");
        idle(12);
        check("post_reset_gate", 64'(voice_gate_o), 64'h0);

        check("exp_queue_empty",  64'(exp_q.size()),      64'h0);
        check("drop_queue_empty", 64'(drop_exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

endmodule
